// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//
// Contents:
//   REG_W       - register-specifier width
//   REG_ZERO    - architectural $0; never a hazard source
//   hz_state_e  - hazard controller FSM states
//   hz_prio_e   - which output-priority level is active in a cycle
package cpu_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  // Highest to lowest priority.
  typedef enum logic [2:0] {
    PRIO_RST    = 3'd0,
    PRIO_ERROR  = 3'd1,
    PRIO_FREEZE = 3'd2,
    PRIO_HAZARD = 3'd3,
    PRIO_FLUSH  = 3'd4,
    PRIO_NORMAL = 3'd5
  } hz_prio_e;

endpackage

// File: rtl/hazard_match.sv
// Compares one producer destination register against the source registers
// of the instruction in ID.
//
// Ports:
//   rd_i      in  producer destination register
//   rs_i      in  rs field of the ID instruction
//   rt_i      in  rt field of the ID instruction
//   use_rs_i  in  ID instruction reads rs
//   use_rt_i  in  ID instruction reads rt
//   match_o   out ID instruction reads rd_i (never true for $0)
module hazard_match
  import cpu_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  output logic             match_o
);

  assign match_o = (rd_i != REG_ZERO) &&
                   (((rd_i == rs_i) && use_rs_i) || ((rd_i == rt_i) && use_rt_i));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS core. Handles what the
// EX forwarding unit cannot: load-use, operand hazards of branches resolved
// in ID, taken-branch flush and data-memory wait. A watchdog on consecutive
// memory-freeze cycles enters a sticky ERROR state that only rst clears.
//
// Optional build macro: HAZARD_STATS_EN adds Stall_Count, Freeze_Count and
// Flush_Count event counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IF_ID_RS/RT, ID_UseRS/RT ID source registers and their use flags
//   ID_Branch, ID_BranchTaken ID branch and its comparator result
//   ID_EX_MemRead/RegWrite/RD EX-stage producer info
//   EX_MEM_MemRead/RD        MEM-stage producer info
//   EX_MEM_MemReq, Mem_Ready data-memory handshake
//   PC_Write .. MEM_WB_Flush pipeline register enables and flushes
//   Stall                    any stall, freeze or error this cycle
//   Mem_Timeout              sticky watchdog error (registered)
//   Dbg_State, Dbg_Freeze_Cnt FSM state and freeze counter for observation
//   Stall_Count, Freeze_Count, Flush_Count (HAZARD_STATS_EN only)
//
// Handshake: a data-memory access is pending while EX_MEM_MemReq is high;
// it completes in the cycle Mem_Ready is high. Every cycle with MemReq high
// and Mem_Ready low freezes the whole pipeline.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_RS,
  input  logic [REG_W-1:0] IF_ID_RT,
  input  logic             ID_UseRS,
  input  logic             ID_UseRT,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [REG_W-1:0] ID_EX_RD,
  input  logic             EX_MEM_MemRead,
  input  logic [REG_W-1:0] EX_MEM_RD,
  input  logic             EX_MEM_MemReq,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             Stall,
  output logic             Mem_Timeout,
  output logic [1:0]       Dbg_State,
  output logic [TO_W-1:0]  Dbg_Freeze_Cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      Stall_Count,
  output logic [31:0]      Freeze_Count,
  output logic [31:0]      Flush_Count
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] freeze_cnt_q, freeze_cnt_d;
  hz_prio_e        prio;

  logic match_ex, match_mem;
  logic freeze, lu, bh, timeout_hit;

  hazard_match u_match_ex (
    .rd_i     (ID_EX_RD),
    .rs_i     (IF_ID_RS),
    .rt_i     (IF_ID_RT),
    .use_rs_i (ID_UseRS),
    .use_rt_i (ID_UseRT),
    .match_o  (match_ex)
  );

  hazard_match u_match_mem (
    .rd_i     (EX_MEM_RD),
    .rs_i     (IF_ID_RS),
    .rt_i     (IF_ID_RT),
    .use_rs_i (ID_UseRS),
    .use_rt_i (ID_UseRT),
    .match_o  (match_mem)
  );

  assign freeze = EX_MEM_MemReq && !Mem_Ready;
  assign lu     = ID_EX_MemRead && match_ex;
  // A branch compares in ID, so it also waits for a load that has only
  // reached MEM; an ALU producer in EX costs one cycle, a load two.
  assign bh     = ID_Branch && ((ID_EX_RegWrite && match_ex) ||
                                (EX_MEM_MemRead && match_mem));

  // ">=" rather than "==" so a counter already past the limit (possible
  // only for MEM_TIMEOUT = 1) still trips the watchdog.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (freeze_cnt_q >= TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (!freeze)          state_d = RUN;
        else if (timeout_hit) state_d = ERROR;
      end
      ERROR:    state_d = ERROR;
      default:  state_d = RUN;
    endcase
  end

  // Counts consecutive freeze cycles; saturates so it cannot wrap to 0.
  always_comb begin
    freeze_cnt_d = '0;
    if (freeze) begin
      freeze_cnt_d = (&freeze_cnt_q) ? freeze_cnt_q : freeze_cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    if (rst)                             prio = PRIO_RST;
    else if (state_q == ERROR)           prio = PRIO_ERROR;
    else if (freeze)                     prio = PRIO_FREEZE;
    else if (lu || bh)                   prio = PRIO_HAZARD;
    else if (ID_Branch && ID_BranchTaken) prio = PRIO_FLUSH;
    else                                 prio = PRIO_NORMAL;
  end

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    Stall        = 1'b0;
    case (prio)
      PRIO_RST: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        MEM_WB_Flush = 1'b1;
        Stall        = 1'b1;
      end
      PRIO_ERROR: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        Stall        = 1'b1;
      end
      PRIO_FREEZE: begin
        // Everything up to EX/MEM holds; the access in MEM is not complete,
        // so MEM/WB receives a bubble each waiting cycle.
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Flush = 1'b1;
        Stall        = 1'b1;
      end
      PRIO_HAZARD: begin
        // Hold PC and IF/ID, let the producer advance, bubble into EX.
        // Any taken result is ignored; the branch is re-evaluated next cycle.
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Flush  = 1'b1;
        Stall        = 1'b1;
      end
      PRIO_FLUSH:  IF_ID_Flush = 1'b1;
      default: ;
    endcase
  end

  assign Mem_Timeout    = (state_q == ERROR);
  assign Dbg_State      = state_q;
  assign Dbg_Freeze_Cnt = freeze_cnt_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, freeze_evt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      freeze_evt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (prio == PRIO_HAZARD) stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (prio == PRIO_FREEZE) freeze_evt_q <= freeze_evt_q + 32'd1;
      if (prio == PRIO_FLUSH)  flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign Stall_Count  = stall_cnt_q;
  assign Freeze_Count = freeze_evt_q;
  assign Flush_Count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (load-use, branch hazards, freeze,
// watchdog, reset mid-freeze, optional statistics counters).
module tb_hazard_stall_ctrl;
  import cpu_pipe_pkg::*;

  // Packed output order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
  // ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush, Stall
  localparam logic [7:0] O_NORM   = 8'b1101_0100;
  localparam logic [7:0] O_HAZ    = 8'b0001_1101;
  localparam logic [7:0] O_FLUSH  = 8'b1111_0100;
  localparam logic [7:0] O_FREEZE = 8'b0000_0011;
  localparam logic [7:0] O_ERR    = 8'b0000_0001;
  localparam logic [7:0] O_RST    = 8'b0010_1011;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst_to;

  // shared inputs
  logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic id_use_rs, id_use_rt, id_branch, id_taken;
  logic id_ex_memread, id_ex_regwrite, ex_mem_memread, ex_mem_memreq, mem_ready;

  // main DUT outputs
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, stall, mem_to;
  logic [1:0] dbg_state;
  logic [7:0] dbg_cnt;
  // watchdog DUT outputs
  logic t_pc_w, t_ifid_w, t_ifid_f, t_idex_w, t_idex_f, t_exmem_w, t_memwb_f, t_stall, t_mem_to;
  logic [1:0] t_dbg_state;
  logic [7:0] t_dbg_cnt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, freeze_count, flush_count;
  logic [31:0] t_stall_count, t_freeze_count, t_flush_count;
`endif

  wire [7:0] outs   = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, stall};
  wire [7:0] t_outs = {t_pc_w, t_ifid_w, t_ifid_f, t_idex_w, t_idex_f, t_exmem_w, t_memwb_f, t_stall};

  hazard_stall_ctrl u_dut (
    .clk(clk), .rst(rst),
    .IF_ID_RS(if_id_rs), .IF_ID_RT(if_id_rt), .ID_UseRS(id_use_rs), .ID_UseRT(id_use_rt),
    .ID_Branch(id_branch), .ID_BranchTaken(id_taken),
    .ID_EX_MemRead(id_ex_memread), .ID_EX_RegWrite(id_ex_regwrite), .ID_EX_RD(id_ex_rd),
    .EX_MEM_MemRead(ex_mem_memread), .EX_MEM_RD(ex_mem_rd),
    .EX_MEM_MemReq(ex_mem_memreq), .Mem_Ready(mem_ready),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f), .ID_EX_Write(idex_w),
    .ID_EX_Flush(idex_f), .EX_MEM_Write(exmem_w), .MEM_WB_Flush(memwb_f), .Stall(stall),
    .Mem_Timeout(mem_to), .Dbg_State(dbg_state), .Dbg_Freeze_Cnt(dbg_cnt)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(stall_count), .Freeze_Count(freeze_count), .Flush_Count(flush_count)
`endif
  );

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) u_dut_to (
    .clk(clk), .rst(rst_to),
    .IF_ID_RS(if_id_rs), .IF_ID_RT(if_id_rt), .ID_UseRS(id_use_rs), .ID_UseRT(id_use_rt),
    .ID_Branch(id_branch), .ID_BranchTaken(id_taken),
    .ID_EX_MemRead(id_ex_memread), .ID_EX_RegWrite(id_ex_regwrite), .ID_EX_RD(id_ex_rd),
    .EX_MEM_MemRead(ex_mem_memread), .EX_MEM_RD(ex_mem_rd),
    .EX_MEM_MemReq(ex_mem_memreq), .Mem_Ready(mem_ready),
    .PC_Write(t_pc_w), .IF_ID_Write(t_ifid_w), .IF_ID_Flush(t_ifid_f), .ID_EX_Write(t_idex_w),
    .ID_EX_Flush(t_idex_f), .EX_MEM_Write(t_exmem_w), .MEM_WB_Flush(t_memwb_f), .Stall(t_stall),
    .Mem_Timeout(t_mem_to), .Dbg_State(t_dbg_state), .Dbg_Freeze_Cnt(t_dbg_cnt)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(t_stall_count), .Freeze_Count(t_freeze_count), .Flush_Count(t_flush_count)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       br;
    logic       tk;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic br, input logic tk, input logic ex_mr,
                        input logic ex_rw, input logic [4:0] ex_rd, input logic mem_mr,
                        input logic [4:0] mem_rd, input logic req, input logic rdy);
    if_id_rs = rs;        if_id_rt = rt;
    id_use_rs = urs;      id_use_rt = urt;
    id_branch = br;       id_taken = tk;
    id_ex_memread = ex_mr; id_ex_regwrite = ex_rw; id_ex_rd = ex_rd;
    ex_mem_memread = mem_mr; ex_mem_rd = mem_rd;
    ex_mem_memreq = req;  mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one cycle: inputs change 1 time unit after the rising edge and
  // are checked on the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"idle",          5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};
    vecs[1]  = '{"lu_rs",         5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, O_HAZ};
    vecs[2]  = '{"lu_rt",         5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, O_HAZ};
    vecs[3]  = '{"lu_rt_unused",  5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};
    vecs[4]  = '{"lu_r0",         5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};
    vecs[5]  = '{"alu_fwd",       5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};
    vecs[6]  = '{"br_alu_ex",     5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, O_HAZ};
    vecs[7]  = '{"br_load_mem",   5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, O_HAZ};
    vecs[8]  = '{"br_haz_taken",  5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, O_HAZ};
    vecs[9]  = '{"br_taken",      5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0, O_FLUSH};
    vecs[10] = '{"freeze_lu",     5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, O_FREEZE};
    vecs[11] = '{"release_taken", 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, O_FLUSH};
    vecs[12] = '{"mem_load_nobr", 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, O_NORM};
    vecs[13] = '{"br_alu_nowr",   5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, O_NORM};

    // ---------------- reset ----------------
    rst = 1'b1;
    rst_to = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outs", 32'(outs), 32'(O_RST));
    check("rst_state", 32'(dbg_state), 32'(RUN));
    check("rst_cnt", 32'(dbg_cnt), 32'd0);
    check("rst_timeout", 32'(mem_to), 32'd0);
    next_cycle();
    rst = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].use_rs, vecs[i].use_rt, vecs[i].br, vecs[i].tk,
             vecs[i].ex_mr, vecs[i].ex_rw, vecs[i].ex_rd, vecs[i].mem_mr, vecs[i].mem_rd,
             vecs[i].req, vecs[i].rdy);
      @(negedge clk);
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      next_cycle();
    end
    idle();
    next_cycle();

    // ---------------- load-use: one bubble ----------------
    set_in(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_c1", 32'(outs), 32'(O_HAZ));
    next_cycle();
    set_in(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_c2", 32'(outs), 32'(O_NORM));
    next_cycle();

    // ---------------- branch after load: two stalls then flush ----------------
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("brld_c1", 32'(outs), 32'(O_HAZ));
    next_cycle();
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("brld_c2", 32'(outs), 32'(O_HAZ));
    next_cycle();
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("brld_c3", 32'(outs), 32'(O_FLUSH));
    next_cycle();

    // same with $0: no stall
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("brld_r0", 32'(outs), 32'(O_NORM));
    next_cycle();

    // ---------------- 5-cycle freeze with taken branch ----------------
    for (int c = 1; c <= 5; c++) begin
      set_in(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("frz_c%0d", c), 32'(outs), 32'(O_FREEZE));
      if (c == 5) begin
        check("frz_state", 32'(dbg_state), 32'(MEM_WAIT));
        check("frz_cnt", 32'(dbg_cnt), 32'd4);
      end
      next_cycle();
    end
    set_in(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("frz_release", 32'(outs), 32'(O_FLUSH));
    next_cycle();
    idle();
    @(negedge clk);
    check("frz_after_state", 32'(dbg_state), 32'(RUN));
    check("frz_after_cnt", 32'(dbg_cnt), 32'd0);
    next_cycle();

    // ---------------- watchdog (MEM_TIMEOUT = 4) ----------------
    rst_to = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("wd_frz%0d_to", c), 32'(t_mem_to), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("wd_err_state", 32'(t_dbg_state), 32'(ERROR));
    check("wd_err_to", 32'(t_mem_to), 32'd1);
    check("wd_err_outs", 32'(t_outs), 32'(O_ERR));
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    check("wd_sticky_to", 32'(t_mem_to), 32'd1);
    check("wd_sticky_outs", 32'(t_outs), 32'(O_ERR));
    next_cycle();
    rst_to = 1'b1;
    @(negedge clk);
    check("wd_rst_outs", 32'(t_outs), 32'(O_RST));
    next_cycle();
    rst_to = 1'b0;
    @(negedge clk);
    check("wd_clr_to", 32'(t_mem_to), 32'd0);
    check("wd_clr_state", 32'(t_dbg_state), 32'(RUN));
    check("wd_clr_outs", 32'(t_outs), 32'(O_NORM));
    next_cycle();

    // ---------------- reset in the middle of a freeze ----------------
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midfrz_rst_outs", 32'(outs), 32'(O_RST));
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("midfrz_state", 32'(dbg_state), 32'(RUN));
    check("midfrz_cnt", 32'(dbg_cnt), 32'd0);
    next_cycle();

`ifdef HAZARD_STATS_EN
    // ---------------- statistics: 3 stalls, 2 freezes, 1 flush ----------------
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_in(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      next_cycle();
    end
    for (int c = 0; c < 2; c++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      next_cycle();
    end
    set_in(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("stat_stall", stall_count, 32'd3);
    check("stat_freeze", freeze_count, 32'd2);
    check("stat_flush", flush_count, 32'd1);
    next_cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
